// File: rtl/bp_nonsynth_cosim_pkg.sv
// Shared types for the co-simulation commit scheduler: FSM state enum and
// a macro that declares the output commit-record struct for a given width.
`ifndef BP_NONSYNTH_COSIM_PKG_SV
`define BP_NONSYNTH_COSIM_PKG_SV

`define BP_COSIM_COMMIT_REC_S(core_w, rec_w) \
   typedef struct packed { \
      logic [core_w-1:0] core; \
      logic [rec_w-1:0]  data; \
   } bp_cosim_commit_rec_s

package bp_nonsynth_cosim_pkg;

   typedef enum logic [2:0] {
      e_idle,
      e_run,
      e_drain,
      e_pass,
      e_fail
   } bp_cosim_arb_state_e;

   // Core-id width; a single core still gets a 1-bit id.
   function automatic int core_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`endif

// File: rtl/bp_nonsynth_cosim_rr_arb.sv
// Combinational round-robin pick: first valid requester at or after ptr,
// wrapping cyclically. Produces one-hot grant, its index and an any flag.
module bp_nonsynth_cosim_rr_arb
   import bp_nonsynth_cosim_pkg::*;
#(
   parameter  int num_core_p = 4,
   localparam int core_w_lp  = core_width(num_core_p)
)(
   input  logic [num_core_p-1:0] v,
   input  logic [core_w_lp-1:0]  ptr,
   output logic [num_core_p-1:0] grant_oh,
   output logic [core_w_lp-1:0]  grant_idx,
   output logic                  grant_any
);

   logic [core_w_lp-1:0] cand;

   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      for (int i = 0; i < num_core_p; i++) begin
         cand = core_w_lp'((int'(ptr) + i) % num_core_p);
         if (!grant_any && v[cand]) begin
            grant_any      = 1'b1;
            grant_idx      = cand;
            grant_oh[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bp_nonsynth_cosim_arbiter.sv
// Multi-core commit scheduler: round-robin grant into a one-entry output
// register feeding the reference checker, plus pass/fail run sequencing.
module bp_nonsynth_cosim_arbiter
   import bp_nonsynth_cosim_pkg::*;
#(
   parameter  int num_core_p     = 4,
   parameter  int rec_width_p    = 256,
   parameter  int stall_cycles_p = 100000,
   localparam int core_w_lp      = core_width(num_core_p)
)(
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic                              en_i,
   input  logic [num_core_p-1:0]             commit_v_i,
   input  logic [num_core_p*rec_width_p-1:0] commit_data_i,
   output logic [num_core_p-1:0]             commit_yumi_o,
   input  logic [num_core_p-1:0]             finish_i,
   output logic                              chk_v_o,
   output logic [core_w_lp-1:0]              chk_core_o,
   output logic [rec_width_p-1:0]            chk_data_o,
   input  logic                              chk_ready_i,
   input  logic                              fail_i,
   output logic                              pass_o,
   output logic                              fail_o,
   output logic                              stall_o
);

   `BP_COSIM_COMMIT_REC_S(core_w_lp, rec_width_p);

   localparam int stall_w_lp = $clog2(stall_cycles_p + 1);

   bp_cosim_arb_state_e   state, state_n;
   bp_cosim_commit_rec_s  chk_r;
   logic [core_w_lp-1:0]  rr_ptr, grant_idx;
   logic [num_core_p-1:0] finish_r, grant_oh, arb_v;
   logic [stall_w_lp-1:0] stall_cnt;
   logic                  grant_any, arb_en, reg_free, hs, stall_expire;

   assign hs       = chk_v_o & chk_ready_i;
   assign reg_free = ~chk_v_o | chk_ready_i;
   assign arb_en   = reg_free & ((state == e_run) | (state == e_drain));
   assign arb_v    = commit_v_i & {num_core_p{arb_en}};

   bp_nonsynth_cosim_rr_arb #(.num_core_p(num_core_p)) u_rr_arb (
      .v         (arb_v),
      .ptr       (rr_ptr),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign commit_yumi_o = grant_oh;
   assign chk_core_o    = chk_r.core;
   assign chk_data_o    = chk_r.data;
   assign pass_o        = (state == e_pass);
   assign fail_o        = (state == e_fail);

   // Fires on the cycle whose increment would land on stall_cycles_p.
   assign stall_expire = (state == e_run) && !hs
                         && (stall_cnt == stall_w_lp'(stall_cycles_p - 1));

   always_comb begin
      state_n = state;
      case (state)
         e_idle:  if (en_i) state_n = e_run;
         e_run: begin
            if (fail_i || stall_expire) state_n = e_fail;
            else if (&finish_r)         state_n = e_drain;
         end
         e_drain: begin
            if (fail_i) state_n = e_fail;
            else if ((commit_v_i == '0) && !chk_v_o && !grant_any) state_n = e_pass;
         end
         default: state_n = state;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state     <= e_idle;
         finish_r  <= '0;
         rr_ptr    <= '0;
         stall_cnt <= '0;
         stall_o   <= 1'b0;
         chk_v_o   <= 1'b0;
         chk_r     <= '0;
      end else begin
         state <= state_n;
         if (state == e_run) finish_r <= finish_r | finish_i;
         if (stall_expire) stall_o <= 1'b1;

         if ((state != e_run) || hs)
            stall_cnt <= '0;
         else if (stall_cnt != stall_w_lp'(stall_cycles_p))
            stall_cnt <= stall_cnt + 1'b1;

         // A same-cycle grant overwrites the record being handed off.
         if (grant_any) begin
            chk_v_o    <= 1'b1;
            chk_r.core <= grant_idx;
            chk_r.data <= commit_data_i[grant_idx*rec_width_p +: rec_width_p];
            rr_ptr     <= (grant_idx == core_w_lp'(num_core_p - 1)) ? '0 : grant_idx + 1'b1;
         end else if (hs) begin
            chk_v_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bp_nonsynth_cosim_arbiter.sv
// Directed bench for the co-sim commit scheduler: round-robin order, wrap,
// backpressure, drain-to-pass, fail priority, stall timeout and async reset.
module tb_bp_nonsynth_cosim_arbiter;

   localparam int N = 4;
   localparam int W = 32;
   localparam int S = 10;

   logic           clk_i = 1'b0;
   logic           reset_i;
   logic           en_i;
   logic [N-1:0]   commit_v_i;
   logic [N*W-1:0] commit_data_i;
   logic [N-1:0]   commit_yumi_o;
   logic [N-1:0]   finish_i;
   logic           chk_v_o;
   logic [1:0]     chk_core_o;
   logic [W-1:0]   chk_data_o;
   logic           chk_ready_i;
   logic           fail_i;
   logic           pass_o, fail_o, stall_o;

   int checks   = 0;
   int failures = 0;

   bp_nonsynth_cosim_arbiter #(
      .num_core_p(N), .rec_width_p(W), .stall_cycles_p(S)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i),
      .commit_v_i(commit_v_i), .commit_data_i(commit_data_i),
      .commit_yumi_o(commit_yumi_o), .finish_i(finish_i),
      .chk_v_o(chk_v_o), .chk_core_o(chk_core_o), .chk_data_o(chk_data_o),
      .chk_ready_i(chk_ready_i), .fail_i(fail_i),
      .pass_o(pass_o), .fail_o(fail_o), .stall_o(stall_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [W-1:0] dat(input int i);
      return 32'hA500_0000 + 32'(i) * 32'h0001_0101;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic apply_reset();
      reset_i     = 1'b1;
      en_i        = 1'b0;
      commit_v_i  = '0;
      finish_i    = '0;
      fail_i      = 1'b0;
      chk_ready_i = 1'b1;
      tick();
      tick();
      reset_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_i    = 1'b1;
      commit_v_i = 4'hF;
      en_i       = 1'b1;
      tick();
      checks++; if (chk_v_o !== 1'b0) begin failures++; $display("FAIL reset_chk_v got=%0h exp=0", chk_v_o); end
      checks++; if (chk_core_o !== 2'd0) begin failures++; $display("FAIL reset_chk_core got=%0h exp=0", chk_core_o); end
      checks++; if (chk_data_o !== '0) begin failures++; $display("FAIL reset_chk_data got=%0h exp=0", chk_data_o); end
      checks++; if (commit_yumi_o !== 4'h0) begin failures++; $display("FAIL reset_yumi got=%0h exp=0", commit_yumi_o); end
      checks++; if ({pass_o, fail_o, stall_o} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%0b exp=000", {pass_o, fail_o, stall_o}); end
      apply_reset();
      // Idle: valid requests but enable low -> no grant.
      commit_v_i = 4'hF;
      #1;
      checks++; if (commit_yumi_o !== 4'h0) begin failures++; $display("FAIL idle_yumi got=%0h exp=0", commit_yumi_o); end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_y;
      apply_reset();
      commit_v_i = 4'hF;
      en_i       = 1'b1;
      tick();
      en_i = 1'b0;  // ignored once running
      for (int k = 0; k < 8; k++) begin
         exp_y = 4'b0001 << (k % 4);
         checks++; if (commit_yumi_o !== exp_y) begin failures++; $display("FAIL rr_yumi k=%0d got=%0h exp=%0h", k, commit_yumi_o, exp_y); end
         tick();
         checks++; if (chk_v_o !== 1'b1 || chk_core_o !== 2'(k % 4)) begin failures++; $display("FAIL rr_chk_core k=%0d got=%0h exp=%0h", k, chk_core_o, k % 4); end
         checks++; if (chk_data_o !== dat(k % 4)) begin failures++; $display("FAIL rr_chk_data k=%0d got=%0h exp=%0h", k, chk_data_o, dat(k % 4)); end
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      en_i = 1'b1;
      tick();
      commit_v_i = 4'b0111;
      for (int k = 0; k < 3; k++) tick();  // grants 0,1,2 -> ptr=3
      commit_v_i = 4'b0100;
      #1;
      checks++; if (commit_yumi_o !== 4'b0100) begin failures++; $display("FAIL wrap_yumi got=%0h exp=4", commit_yumi_o); end
      tick();
      checks++; if (chk_core_o !== 2'd2) begin failures++; $display("FAIL wrap_core got=%0h exp=2", chk_core_o); end
      // Pointer went back to 3, so core 3 beats core 0.
      commit_v_i = 4'b1101;
      #1;
      checks++; if (commit_yumi_o !== 4'b1000) begin failures++; $display("FAIL wrap_ptr_yumi got=%0h exp=8", commit_yumi_o); end
      tick();
      checks++; if (chk_core_o !== 2'd3) begin failures++; $display("FAIL wrap_ptr_core got=%0h exp=3", chk_core_o); end
      commit_v_i = '0;
   endtask

   task automatic test_backpressure();
      apply_reset();
      en_i       = 1'b1;
      commit_v_i = 4'hF;
      tick();
      tick();  // core 0 loaded
      chk_ready_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++; if (commit_yumi_o !== 4'h0) begin failures++; $display("FAIL bp_yumi k=%0d got=%0h exp=0", k, commit_yumi_o); end
         checks++; if (chk_v_o !== 1'b1 || chk_core_o !== 2'd0 || chk_data_o !== dat(0)) begin failures++; $display("FAIL bp_hold k=%0d got=%0h exp=%0h", k, chk_data_o, dat(0)); end
         tick();
      end
      chk_ready_i = 1'b1;
      #1;
      checks++; if (commit_yumi_o !== 4'b0010) begin failures++; $display("FAIL bp_release_yumi got=%0h exp=2", commit_yumi_o); end
      tick();
      checks++; if (chk_v_o !== 1'b1 || chk_core_o !== 2'd1 || chk_data_o !== dat(1)) begin failures++; $display("FAIL bp_release_rec got=%0h exp=%0h", chk_data_o, dat(1)); end
      commit_v_i = '0;
   endtask

   task automatic test_drain_pass();
      int cnt1, cnt3, exp_core, n;
      logic [N-1:0] exp_y;
      apply_reset();
      en_i = 1'b1;
      tick();
      finish_i = 4'b0101;
      tick();
      finish_i = 4'b0010;
      tick();
      finish_i = 4'b1000;
      cnt1 = 4; cnt3 = 4; exp_core = 1; n = 0;
      while ((cnt1 > 0 || cnt3 > 0) && n < 20) begin
         commit_v_i = {cnt3 > 0, 1'b0, cnt1 > 0, 1'b0};
         #1;
         exp_y = 4'b0001 << exp_core;
         checks++; if (commit_yumi_o !== exp_y) begin failures++; $display("FAIL drain_yumi n=%0d got=%0h exp=%0h", n, commit_yumi_o, exp_y); end
         checks++; if (pass_o !== 1'b0) begin failures++; $display("FAIL drain_early_pass n=%0d got=%0b exp=0", n, pass_o); end
         if (exp_core == 1) cnt1--; else cnt3--;
         exp_core = (exp_core == 1) ? 3 : 1;
         n++;
         tick();
         finish_i = '0;
      end
      checks++; if (n >= 20) begin failures++; $display("FAIL drain_timeout got=%0d exp<20", n); end
      commit_v_i = '0;
      checks++; if (chk_v_o !== 1'b1 || chk_core_o !== 2'd3) begin failures++; $display("FAIL drain_last_core got=%0h exp=3", chk_core_o); end
      tick();
      checks++; if (chk_v_o !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0b exp=0", chk_v_o); end
      tick();
      checks++; if (pass_o !== 1'b1 || fail_o !== 1'b0) begin failures++; $display("FAIL drain_pass got=%0b%0b exp=10", pass_o, fail_o); end
      commit_v_i = 4'hF;
      #1;
      checks++; if (commit_yumi_o !== 4'h0) begin failures++; $display("FAIL pass_no_grant got=%0h exp=0", commit_yumi_o); end
      commit_v_i = '0;
   endtask

   task automatic test_fail_wins();
      apply_reset();
      en_i = 1'b1;
      tick();
      finish_i = 4'hF;
      tick();
      finish_i = '0;
      tick();  // now in drain with nothing pending
      fail_i = 1'b1;
      tick();
      fail_i = 1'b0;
      checks++; if (fail_o !== 1'b1 || pass_o !== 1'b0) begin failures++; $display("FAIL failwins got=%0b%0b exp=10", fail_o, pass_o); end
      checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL failwins_stall got=%0b exp=0", stall_o); end
      tick();
      checks++; if (fail_o !== 1'b1 || pass_o !== 1'b0) begin failures++; $display("FAIL fail_terminal got=%0b%0b exp=10", fail_o, pass_o); end
   endtask

   task automatic test_stall();
      apply_reset();
      en_i = 1'b1;
      tick();  // enter run, counter 0
      for (int k = 1; k < S; k++) begin
         tick();
         checks++; if (fail_o !== 1'b0) begin failures++; $display("FAIL stall_early k=%0d got=%0b exp=0", k, fail_o); end
      end
      tick();
      checks++; if (fail_o !== 1'b1 || stall_o !== 1'b1) begin failures++; $display("FAIL stall_fire got=%0b%0b exp=11", fail_o, stall_o); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      en_i        = 1'b1;
      chk_ready_i = 1'b0;
      tick();
      commit_v_i = 4'b0100;
      tick();  // core 2 loaded, held by backpressure
      commit_v_i = '0;
      tick();
      tick();
      checks++; if (chk_v_o !== 1'b1 || chk_core_o !== 2'd2) begin failures++; $display("FAIL areset_pre got=%0h exp=2", chk_core_o); end
      #2;
      reset_i = 1'b1;  // mid-cycle, away from any clock edge
      #1;
      checks++; if (chk_v_o !== 1'b0 || chk_core_o !== 2'd0 || chk_data_o !== '0) begin failures++; $display("FAIL areset_reg got=%0b/%0h/%0h exp=0/0/0", chk_v_o, chk_core_o, chk_data_o); end
      checks++; if ({pass_o, fail_o, stall_o} !== 3'b000 || commit_yumi_o !== 4'h0) begin failures++; $display("FAIL areset_flags got=%0b/%0h exp=000/0", {pass_o, fail_o, stall_o}, commit_yumi_o); end
      chk_ready_i = 1'b1;
      tick();
      reset_i = 1'b0;
   endtask

   initial begin
      reset_i     = 1'b1;
      en_i        = 1'b0;
      commit_v_i  = '0;
      finish_i    = '0;
      fail_i      = 1'b0;
      chk_ready_i = 1'b1;
      for (int i = 0; i < N; i++) commit_data_i[i*W +: W] = dat(i);
      #2;
      test_reset();
      test_round_robin();
      test_wrap();
      test_backpressure();
      test_drain_pass();
      test_fail_wins();
      test_stall();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
